// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file port arbiter.
//   WORD        : register-file data width
//   SEL_W       : register select width (64 registers)
//   reg_mode_e  : register_file.mode command encodings (idle / write-in / read-out)
//   req_id_e    : read requester identifiers carried through the tag pipeline
//   rd_tag_t    : one in-flight read tag (valid + requester id)
package regfile_port_arbiter_pkg;

  localparam int WORD  = 16;
  localparam int SEL_W = 6;

  typedef enum logic [1:0] {
    regModeIdle = 2'b00,
    regModeIn   = 2'b01,
    regModeOut  = 2'b10
  } reg_mode_e;

  typedef enum logic {
    REQ_RD0 = 1'b0,
    REQ_RD1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

  localparam rd_tag_t TAG_EMPTY = '{valid: 1'b0, id: REQ_RD0};

endpackage

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker for the operand-read requesters.
//   clk     : rising-edge clock
//   clear   : asynchronous active-low reset (pointer returns to requester 0)
//   req     : request vector, bit 0 = rd0, bit 1 = rd1
//   advance : flip the preferred requester at the end of this cycle
//   gnt     : one-hot grant (combinational)
module rr_arb2 (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 0 prefers rd0, 1 prefers rd1
  logic ptr;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~ptr;
    end
  end

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares the single-port 64x16 register_file between one
// writeback requester and two operand-read requesters, one access per cycle.
//   clk, clear            : clock; asynchronous active-low reset
//   wr_req/wr_sel/wr_data : writeback request; wr_gnt accepts it (combinational)
//   wr_err                : one-cycle pulse after an accepted write to a constant register
//   rdX_req/rdX_sel       : operand read requests; rdX_gnt accepts them (combinational)
//   rdX_valid/rdX_data    : read return, two cycles after grant; data is 0 when not valid
//   rf_mode/rf_sel/rf_data_in : registered command to register_file
//   rf_data_out           : register_file read data
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int PROT_REGS    = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              wr_req,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [WORD-1:0]   wr_data,
  output logic              wr_gnt,
  output logic              wr_err,
  input  logic              rd0_req,
  input  logic [SEL_W-1:0]  rd0_sel,
  input  logic              rd1_req,
  input  logic [SEL_W-1:0]  rd1_sel,
  output logic              rd0_gnt,
  output logic              rd1_gnt,
  output logic              rd0_valid,
  output logic              rd1_valid,
  output logic [WORD-1:0]   rd0_data,
  output logic [WORD-1:0]   rd1_data,
  output logic [1:0]        rf_mode,
  output logic [SEL_W-1:0]  rf_sel,
  output logic [WORD-1:0]   rf_data_in,
  input  logic [WORD-1:0]   rf_data_out
);

  localparam logic [2:0]       STARVE_MAX = 3'(STARVE_LIMIT);
  localparam logic [SEL_W-1:0] PROT_TOP   = SEL_W'(PROT_REGS);

  logic             rd_pending;
  logic             starve_hit;
  logic             wr_grant;
  logic             wr_prot;
  logic [1:0]       rd_req_m;
  logic [1:0]       rd_grant;
  logic [2:0]       starve_cnt, starve_nxt;

  reg_mode_e        mode_q, mode_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WORD-1:0]  din_q, din_d;
  logic             err_q, err_d;
  rd_tag_t          tag0_q, tag1_q, tag0_d;

  // ---------------- grant selection ----------------
  assign rd_pending = rd0_req | rd1_req;
  assign starve_hit = rd_pending && (starve_cnt == STARVE_MAX);
  assign wr_grant   = clear && wr_req && !starve_hit;
  assign wr_prot    = (wr_sel < PROT_TOP);

  // Reads only compete when the write is not taking the slot.
  assign rd_req_m = {rd1_req, rd0_req} & {2{clear && !wr_grant}};

  rr_arb2 u_rr (
    .clk     (clk),
    .clear   (clear),
    .req     (rd_req_m),
    .advance (|rd_grant),
    .gnt     (rd_grant)
  );

  assign wr_gnt  = wr_grant;
  assign rd0_gnt = rd_grant[0];
  assign rd1_gnt = rd_grant[1];

  // ---------------- starvation counter ----------------
  always_comb begin
    starve_nxt = starve_cnt;
    if ((|rd_grant) || !rd_pending) begin
      starve_nxt = '0;
    end else if (wr_grant && (starve_cnt != STARVE_MAX)) begin
      starve_nxt = starve_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

  // ---------------- command register ----------------
  // A protected write still loads sel/data so the error pulse lines up with
  // the command it replaced; only the mode is suppressed to idle.
  always_comb begin
    mode_d = regModeIdle;
    sel_d  = sel_q;
    din_d  = din_q;
    err_d  = 1'b0;
    tag0_d = TAG_EMPTY;
    if (wr_grant) begin
      sel_d = wr_sel;
      din_d = wr_data;
      if (wr_prot) begin
        err_d = 1'b1;
      end else begin
        mode_d = regModeIn;
      end
    end else if (rd_grant[0]) begin
      mode_d = regModeOut;
      sel_d  = rd0_sel;
      tag0_d = '{valid: 1'b1, id: REQ_RD0};
    end else if (rd_grant[1]) begin
      mode_d = regModeOut;
      sel_d  = rd1_sel;
      tag0_d = '{valid: 1'b1, id: REQ_RD1};
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      mode_q <= regModeIdle;
      sel_q  <= '0;
      din_q  <= '0;
      err_q  <= 1'b0;
      tag0_q <= TAG_EMPTY;
      tag1_q <= TAG_EMPTY;
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
      din_q  <= din_d;
      err_q  <= err_d;
      tag0_q <= tag0_d;
      tag1_q <= tag0_q;
    end
  end

  assign rf_mode    = mode_q;
  assign rf_sel     = sel_q;
  assign rf_data_in = din_q;
  assign wr_err     = err_q;

  // ---------------- read return ----------------
  // Second tag stage lines up with register_file.data_out after its read edge.
  assign rd0_valid = tag1_q.valid && (tag1_q.id == REQ_RD0);
  assign rd1_valid = tag1_q.valid && (tag1_q.id == REQ_RD1);
  assign rd0_data  = rd0_valid ? rf_data_out : '0;
  assign rd1_data  = rd1_valid ? rf_data_out : '0;

endmodule
